ysyx_24100029_alu_arb: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one `ysyx_24100029_ALU` instance between two requesters (e.g. EXU and a branch/address unit). It accepts one operation at a time over valid/ready, holds the operands stable on the ALU for a full cycle, and registers the result. It returns the result to the owning requester over a second valid/ready channel. The block sits between the requesters and the ALU; the ALU is instantiated outside it.

---
 rtl/ysyx_24100029_alu_arb.sv | 143 ++++++++++++++
 tb/tb_ysyx_24100029_alu_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_alu_arb.sv
// ysyx_24100029_alu_arb
// Round-robin arbiter and sequencer that shares one external ALU between two
// requesters. One operation is accepted at a time. Its operands are held on
// the ALU for a full cycle, and the result is registered. The result is then
// returned to the owning requester over a valid/ready response channel.
//
// Ports:
//   clk, rst                     rising-edge clock, async active-high reset
//   reqN_valid/ready             request handshake, N = 0,1
//   reqN_d1/d2/choice            operands and ALU op code
//   rspN_valid/ready             response handshake, N = 0,1
//   rspN_res/overflow            registered ALU result and overflow flag
//   alu_d1/d2/choice             operands driven to the ALU
//   alu_res/overflow             result returned by the ALU
//
// Configuration macro:
//   YSYX_24100029_ALU_ARB_FIXED_PRIO_EN  requester 0 always wins a tie
//                                        (default: round-robin on ties)
module ysyx_24100029_alu_arb #(
   parameter int unsigned BW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [BW-1:0] req0_d1,
   input  logic [BW-1:0] req0_d2,
   input  logic [3:0]    req0_choice,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [BW-1:0] req1_d1,
   input  logic [BW-1:0] req1_d2,
   input  logic [3:0]    req1_choice,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [BW-1:0] rsp0_res,
   output logic          rsp0_overflow,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [BW-1:0] rsp1_res,
   output logic          rsp1_overflow,
   output logic [BW-1:0] alu_d1,
   output logic [BW-1:0] alu_d2,
   output logic [3:0]    alu_choice,
   input  logic [BW-1:0] alu_res,
   input  logic          alu_overflow
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] op_d1, op_d2;
   logic [3:0]    op_choice;
   logic [BW-1:0] res_q;
   logic          ovf_q;
   logic          owner_q;
   logic          gnt0, gnt1;
   logic          accept;

`ifndef YSYX_24100029_ALU_ARB_FIXED_PRIO_EN
   // Requester granted most recently. It resets to 1 so that requester 0
   // wins the first tie.
   logic last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= gnt1;
      end
   end
`endif

   // Grant depends only on the valids and the state/priority registers.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
`ifdef YSYX_24100029_ALU_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            gnt0 = last_q;
            gnt1 = ~last_q;
`endif
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign accept = gnt0 | gnt1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_d1     <= '0;
         op_d2     <= '0;
         op_choice <= '0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         owner_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_d1     <= gnt1 ? req1_d1     : req0_d1;
            op_d2     <= gnt1 ? req1_d2     : req0_d2;
            op_choice <= gnt1 ? req1_choice : req0_choice;
            owner_q   <= gnt1;
         end
         if (state_q == EXEC) begin
            res_q <= alu_res;
            ovf_q <= alu_overflow;
         end
      end
   end

   assign req0_ready    = gnt0;
   assign req1_ready    = gnt1;

   assign alu_d1        = op_d1;
   assign alu_d2        = op_d2;
   assign alu_choice    = op_choice;

   assign rsp0_valid    = (state_q == RESP) && !owner_q;
   assign rsp1_valid    = (state_q == RESP) &&  owner_q;
   assign rsp0_res      = res_q;
   assign rsp1_res      = res_q;
   assign rsp0_overflow = ovf_q;
   assign rsp1_overflow = ovf_q;

endmodule

// File: tb/tb_ysyx_24100029_alu_arb.sv
module tb_ysyx_24100029_alu_arb;

   localparam int unsigned BW = 32;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [BW-1:0] req0_d1 = '0, req0_d2 = '0, req1_d1 = '0, req1_d2 = '0;
   logic [3:0]    req0_choice = '0, req1_choice = '0;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [BW-1:0] rsp0_res, rsp1_res;
   logic          rsp0_overflow, rsp1_overflow;
   logic [BW-1:0] alu_d1, alu_d2, alu_res;
   logic [3:0]    alu_choice;
   logic          alu_overflow;

   typedef struct {
      int            owner;
      logic [BW-1:0] res;
      logic          ovf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_24100029_alu_arb #(.BW(BW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_d1(req0_d1), .req0_d2(req0_d2), .req0_choice(req0_choice),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_d1(req1_d1), .req1_d2(req1_d2), .req1_choice(req1_choice),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_res(rsp0_res), .rsp0_overflow(rsp0_overflow),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_res(rsp1_res), .rsp1_overflow(rsp1_overflow),
      .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_choice(alu_choice),
      .alu_res(alu_res), .alu_overflow(alu_overflow)
   );

   // Stand-in for the external ALU: add and subtract with signed overflow.
   always_comb begin
      alu_res      = '0;
      alu_overflow = 1'b0;
      case (alu_choice)
         OP_ADD: begin
            alu_res      = alu_d1 + alu_d2;
            alu_overflow = (alu_d1[BW-1] == alu_d2[BW-1]) && (alu_res[BW-1] != alu_d1[BW-1]);
         end
         OP_SUB: begin
            alu_res      = alu_d1 - alu_d2;
            alu_overflow = (alu_d1[BW-1] != alu_d2[BW-1]) && (alu_res[BW-1] != alu_d1[BW-1]);
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response is consumed.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 1, 0);
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (rsp1_valid) begin
                  check("rsp_owner", 1, e.owner);
                  check("rsp1_res", rsp1_res, e.res);
                  check("rsp1_ovf", rsp1_overflow, e.ovf);
               end else begin
                  check("rsp_owner", 0, e.owner);
                  check("rsp0_res", rsp0_res, e.res);
                  check("rsp0_ovf", rsp0_overflow, e.ovf);
               end
            end
         end
      end
   end

   task automatic push(input int owner, input logic [BW-1:0] res, input logic ovf);
      exp_t e;
      e.owner = owner; e.res = res; e.ovf = ovf;
      sb.push_back(e);
   endtask

   task automatic set_req(input int n, input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                          input logic [3:0] ch);
      if (n == 0) begin
         req0_valid = 1'b1; req0_d1 = d1; req0_d2 = d2; req0_choice = ch;
      end else begin
         req1_valid = 1'b1; req1_d1 = d1; req1_d2 = d2; req1_choice = ch;
      end
   endtask

   // Issue one op on requester n; returns 1 time unit after the accept edge.
   task automatic issue(input int n, input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                        input logic [3:0] ch, input logic [BW-1:0] er, input logic eo);
      bit got = 0;
      set_req(n, d1, d2, ch);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) got = 1;
      end
      check("accept_seen", got, 1);
      if (got) push(n, er, eo);
      @(posedge clk); #1;
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_empty();
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0) done = 1;
      end
      check("drain_in_time", done, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, last_cyc;
      bit [1:0] exp_grants [4];

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_alu_d1", alu_d1, 0);
      check("rst_rsp0_res", rsp0_res, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single add on requester 0 with 2-cycle latency.
      issue(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
      @(negedge clk);
      check("lat_exec_rsp0_valid", rsp0_valid, 0);
      @(negedge clk);
      check("lat_resp_rsp0_valid", rsp0_valid, 1);
      check("lat_resp_rsp1_valid", rsp1_valid, 0);
      wait_empty();

      // Subtract with signed overflow on requester 1.
      issue(1, 32'h8000_0000, 32'd1, OP_SUB, 32'h7FFF_FFFF, 1'b1);
      wait_empty();

      // Continuous tie: last grant was 1, so the grants run 0,1,0,1.
`ifdef YSYX_24100029_ALU_ARB_FIXED_PRIO_EN
      exp_grants = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_grants = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
      set_req(0, 32'd1, 32'd2, OP_ADD);
      set_req(1, 32'd10, 32'd20, OP_ADD);
      acc = 0; last_cyc = 0;
      for (int i = 0; i < 30 && acc < 4; i++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) check("tie_both_ready", 1, 0);
         if (req0_ready || req1_ready) begin
            check("tie_grant", {1'b0, req1_ready}, exp_grants[acc]);
            if (acc > 0) check("tie_spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
            if (req1_ready) push(1, 32'd30, 1'b0); else push(0, 32'd3, 1'b0);
            acc++;
         end
      end
      check("tie_accepts", acc, 4);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_empty();

      // Response stall: requester 1 must wait while rsp0 is unconsumed.
      rsp0_ready = 1'b0;
      issue(0, 32'h10, 32'h20, OP_ADD, 32'h30, 1'b0);
      set_req(1, 32'd3, 32'd4, OP_SUB);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_req1_ready", req1_ready, 0);
         check("stall_rsp0_valid", rsp0_valid, 1);
         check("stall_rsp0_res", rsp0_res, 32'h30);
      end
      @(posedge clk); #1 rsp0_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("post_stall_req1_ready", req1_ready, 1);
      if (req1_ready) push(1, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_empty();

      // Reset during EXEC discards the op and restores the tie priority to 0.
      issue(0, 32'd50, 32'd60, OP_ADD, 32'd110, 1'b0);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_rsp0_valid", rsp0_valid, 0);
      check("mid_rst_rsp1_valid", rsp1_valid, 0);
      check("mid_rst_alu_d1", alu_d1, 0);
      @(posedge clk); #1 rst = 1'b0;
      set_req(0, 32'd1, 32'd1, OP_ADD);
      set_req(1, 32'd2, 32'd2, OP_ADD);
      @(negedge clk);
      check("post_rst_req0_ready", req0_ready, 1);
      check("post_rst_req1_ready", req1_ready, 0);
      if (req0_ready) push(0, 32'd2, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_empty();

      // Operands are sampled only at the accept edge.
      issue(0, 32'd100, 32'd1, OP_ADD, 32'd101, 1'b0);
      req0_d1 = 32'd999;
      @(negedge clk);
      check("held_alu_d1", alu_d1, 32'd100);
      wait_empty();

      check("sb_empty_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
